// File: rtl/bullet_manager.sv
// rtl/bullet_manager.sv - player projectile slots: spawn, move, retire and per-pixel render
// Ports:
//   Clk, Reset         clock; synchronous active-high reset
//   VS                 raw vertical sync level; its rising edge is the frame tick
//   gameState          00 START, 01 PLAY, 10 GAMEOVER; slots only live in PLAY
//   Shooting, Facing   fire key level, player facing (1 = right)
//   PlayerX/Y/Width    player sprite top-left and width
//   ScrollEnable       background scrolled this frame (used with BULLET_SCROLL_COMP_EN)
//   DrawX, DrawY       current pixel coordinate
//   bulletOn/Pixel     registered hit flag and colour, 1 Clk behind DrawX/DrawY
//   activeCount        number of live slots
//   fireEvent          one-cycle pulse per successful spawn
// Optional: define BULLET_SCROLL_COMP_EN to drift bullets left with the scrolling background.
module bullet_manager #(
    parameter int         NUM_BULLETS  = 4,
    parameter int         BULLET_W     = 4,
    parameter int         BULLET_H     = 2,
    parameter int         SPEED        = 6,
    parameter int         COOLDOWN     = 8,
    parameter int         MUZZLE_Y     = 12,
    parameter logic [4:0] BULLET_COLOR = 5'd17,
    parameter int         SCROLL_STEP  = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VS,
    input  logic [1:0] gameState,
    input  logic       Shooting,
    input  logic       Facing,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    input  logic [9:0] PlayerWidth,
    input  logic       ScrollEnable,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       bulletOn,
    output logic [4:0] bulletPixel,
    output logic [3:0] activeCount,
    output logic       fireEvent
);

    localparam logic [1:0]         PLAY    = 2'b01;
    localparam logic signed [11:0] XMAX_S  = 12'(640 - BULLET_W);
    localparam logic [10:0]        XMAX_U  = 11'(640 - BULLET_W);
    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic [10:0]        W_M1    = 11'(BULLET_W - 1);
    localparam logic [10:0]        H_M1    = 11'(BULLET_H - 1);

    logic [NUM_BULLETS-1:0] active_q, active_n;
    logic [NUM_BULLETS-1:0] dir_q, dir_n;
    logic [9:0]             x_q [NUM_BULLETS];
    logic [9:0]             x_n [NUM_BULLETS];
    logic [9:0]             y_q [NUM_BULLETS];
    logic [9:0]             y_n [NUM_BULLETS];

    logic       vs_d, shoot_d, pending;
    logic [7:0] cooldown;
    logic       tick, placed, pos_ok, spawn_req, hit;
    logic [10:0] right_x;
    logic [9:0]  spawn_x, spawn_y;
    logic signed [11:0] nx;
    logic [3:0] count_n;

    assign tick = VS & ~vs_d;

`ifdef BULLET_SCROLL_COMP_EN
    localparam logic signed [11:0] STEP_S = 12'(SCROLL_STEP);
`else
    logic unused_scroll;
    assign unused_scroll = ScrollEnable ^ (SCROLL_STEP != 0);
`endif

    // Spawn position: ahead of the player on the side it faces.
    always_comb begin
        right_x = {1'b0, PlayerX} + {1'b0, PlayerWidth};
        spawn_y = PlayerY + 10'(MUZZLE_Y);
        if (Facing) begin
            spawn_x = right_x[9:0];
            pos_ok  = (right_x <= XMAX_U);
        end else begin
            spawn_x = PlayerX - 10'(BULLET_W);
            pos_ok  = (PlayerX >= 10'(BULLET_W));
        end
        spawn_req = pending && (cooldown == 8'd0) && pos_ok;
    end

    // Next slot state for a tick: move/retire every live slot, then place the
    // new bullet in the lowest free slot so it does not move on its spawn tick.
    always_comb begin
        active_n = active_q;
        dir_n    = dir_q;
        x_n      = x_q;
        y_n      = y_q;
        nx       = '0;
        placed   = 1'b0;
        if (tick) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (active_q[i]) begin
                    nx = dir_q[i] ? $signed({2'b00, x_q[i]}) + SPEED_S
                                  : $signed({2'b00, x_q[i]}) - SPEED_S;
                    if (nx < 0 || nx > XMAX_S) active_n[i] = 1'b0;
                    else                       x_n[i]      = nx[9:0];
`ifdef BULLET_SCROLL_COMP_EN
                    if (active_n[i] && ScrollEnable) begin
                        nx = $signed({2'b00, x_n[i]}) - STEP_S;
                        if (nx < 0) active_n[i] = 1'b0;
                        else        x_n[i]      = nx[9:0];
                    end
`endif
                end
            end
            if (spawn_req) begin
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (!placed && !active_n[i]) begin
                        placed      = 1'b1;
                        active_n[i] = 1'b1;
                        x_n[i]      = spawn_x;
                        y_n[i]      = spawn_y;
                        dir_n[i]    = Facing;
                    end
                end
            end
        end
        count_n = '0;
        for (int i = 0; i < NUM_BULLETS; i++) count_n = count_n + 4'(active_n[i]);
    end

    // Pixel hit test in 11 bits so x+W-1 near the right edge cannot wrap.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (active_q[i]
                && {1'b0, DrawX} >= {1'b0, x_q[i]} && {1'b0, DrawX} <= {1'b0, x_q[i]} + W_M1
                && {1'b0, DrawY} >= {1'b0, y_q[i]} && {1'b0, DrawY} <= {1'b0, y_q[i]} + H_M1)
                hit = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_d        <= 1'b0;
            shoot_d     <= 1'b0;
            pending     <= 1'b0;
            cooldown    <= '0;
            active_q    <= '0;
            dir_q       <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            bulletOn    <= 1'b0;
            bulletPixel <= '0;
            activeCount <= '0;
            fireEvent   <= 1'b0;
        end else begin
            vs_d        <= VS;
            shoot_d     <= Shooting;
            bulletOn    <= hit;
            bulletPixel <= hit ? BULLET_COLOR : 5'd0;
            if (gameState != PLAY) begin
                active_q    <= '0;
                pending     <= 1'b0;
                cooldown    <= '0;
                activeCount <= '0;
                fireEvent   <= 1'b0;
            end else begin
                active_q    <= active_n;
                dir_q       <= dir_n;
                x_q         <= x_n;
                y_q         <= y_n;
                activeCount <= count_n;
                fireEvent   <= placed;
                if (tick)                     pending <= 1'b0;
                else if (Shooting && !shoot_d) pending <= 1'b1;
                // The spawn tick counts as the first cooldown frame, so spawns
                // end up exactly COOLDOWN ticks apart.
                if (tick) begin
                    if (placed)                cooldown <= 8'(COOLDOWN - 1);
                    else if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_manager.sv
// tb/tb_bullet_manager.sv - directed self-checking bench for bullet_manager
module tb_bullet_manager;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       VS = 1'b0;
    logic [1:0] gameState = 2'b01;
    logic       Shooting = 1'b0;
    logic       Facing = 1'b1;
    logic [9:0] PlayerX = 10'd100;
    logic [9:0] PlayerY = 10'd200;
    logic [9:0] PlayerWidth = 10'd32;
    logic       ScrollEnable = 1'b0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       bulletOn;
    logic [4:0] bulletPixel;
    logic [3:0] activeCount;
    logic       fireEvent;

    int n_checks = 0;
    int n_pass   = 0;

    bullet_manager dut (
        .Clk(Clk), .Reset(Reset), .VS(VS), .gameState(gameState),
        .Shooting(Shooting), .Facing(Facing), .PlayerX(PlayerX), .PlayerY(PlayerY),
        .PlayerWidth(PlayerWidth), .ScrollEnable(ScrollEnable),
        .DrawX(DrawX), .DrawY(DrawY), .bulletOn(bulletOn), .bulletPixel(bulletPixel),
        .activeCount(activeCount), .fireEvent(fireEvent)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One frame: VS rises, the tick edge is sampled, then VS drops.
    task automatic frame(output int fire);
        @(negedge Clk) VS = 1'b1;
        @(posedge Clk);
        #1 fire = int'(fireEvent);
        @(negedge Clk) VS = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_shoot();
        @(negedge Clk) Shooting = 1'b1;
        @(negedge Clk) Shooting = 1'b0;
    endtask

    task automatic probe(input int dx, input int dy, output int on, output int pix);
        @(negedge Clk);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        @(posedge Clk);
        #1;
        on  = int'(bulletOn);
        pix = int'(bulletPixel);
    endtask

    // Confirms a lone bullet's exact footprint at (x, y).
    task automatic check_at(input string tag, input int x, input int y);
        int on, pix;
        probe(x, y, on, pix);
        check({tag, " on"}, on, 1);
        check({tag, " pix"}, pix, 17);
        probe(x + 3, y + 1, on, pix);
        check({tag, " far corner"}, on, 1);
        probe(x + 4, y, on, pix);
        check({tag, " right of"}, on, 0);
        probe(x, y + 2, on, pix);
        check({tag, " below"}, on, 0);
        if (x > 0) begin
            probe(x - 1, y, on, pix);
            check({tag, " left of"}, on, 0);
        end
    endtask

    task automatic clear_play();
        @(negedge Clk) gameState = 2'b10;
        @(negedge Clk) gameState = 2'b01;
    endtask

    initial begin
        int fire, fires, on, pix, exp_x;

        // Reset
        repeat (3) @(posedge Clk);
        #1;
        check("reset bulletOn", int'(bulletOn), 0);
        check("reset bulletPixel", int'(bulletPixel), 0);
        check("reset activeCount", int'(activeCount), 0);
        check("reset fireEvent", int'(fireEvent), 0);
        @(negedge Clk) Reset = 1'b0;
        fires = 0;
        for (int k = 0; k < 5; k++) begin
            frame(fire);
            fires += fire;
        end
        check("idle fires", fires, 0);
        check("idle activeCount", int'(activeCount), 0);

        // Right-facing spawn and movement
        pulse_shoot();
        frame(fire);
        check("spawn fire", fire, 1);
        check("spawn fire one cycle", int'(fireEvent), 0);
        check("spawn count", int'(activeCount), 1);
        check_at("spawn pos", 132, 212);
        frame(fire);
        check("move fire", fire, 0);
        check_at("moved pos", 138, 212);
        probe(142, 212, on, pix);
        check("x=142 off", on, 0);
        check("x=142 pix", pix, 0);

        // Holding the key spawns once
        clear_play();
        check("clear count", int'(activeCount), 0);
        @(negedge Clk) Shooting = 1'b1;
        fires = 0;
        for (int k = 0; k < 20; k++) begin
            frame(fire);
            fires += fire;
        end
        @(negedge Clk) Shooting = 1'b0;
        check("hold fires", fires, 1);

        // Toggled key: spawns 8 ticks apart, fifth request dropped with slots full
        clear_play();
        for (int k = 0; k <= 32; k++) begin
            pulse_shoot();
            frame(fire);
            check($sformatf("toggle frame %0d", k), fire, (k % 8 == 0 && k < 32) ? 1 : 0);
        end
        check("full activeCount", int'(activeCount), 4);

        // Left-facing: blocked at the edge, then retire past x=0
        clear_play();
        Facing  = 1'b0;
        PlayerX = 10'd2;
        pulse_shoot();
        frame(fire);
        check("left edge fire", fire, 0);
        check("left edge count", int'(activeCount), 0);
        PlayerX = 10'd10;
        pulse_shoot();
        frame(fire);
        check("left fire", fire, 1);
        check_at("left spawn", 6, 212);
        frame(fire);
        check_at("left at zero", 0, 212);
        check("left at zero count", int'(activeCount), 1);
        frame(fire);
        check("left retired", int'(activeCount), 0);

        // Right boundary
        clear_play();
        Facing  = 1'b1;
        PlayerX = 10'd605;
        pulse_shoot();
        frame(fire);
        check("right 637 dropped", fire, 0);
        PlayerX = 10'd598;
        pulse_shoot();
        frame(fire);
        check("right 630 fire", fire, 1);
        check_at("right 630", 630, 212);
        frame(fire);
        check_at("right 636", 636, 212);
        frame(fire);
        check("right retired", int'(activeCount), 0);

        // GAMEOVER mid-flight
        clear_play();
        PlayerX = 10'd100;
        pulse_shoot();
        frame(fire);
        check("pre-gameover count", int'(activeCount), 1);
        @(negedge Clk) gameState = 2'b10;
        @(posedge Clk);
        #1 check("gameover count", int'(activeCount), 0);
        probe(132, 212, on, pix);
        check("gameover render", on, 0);
        @(negedge Clk) gameState = 2'b01;

        // Scroll compensation
        clear_play();
        pulse_shoot();
        frame(fire);
        check("scroll spawn fire", fire, 1);
        ScrollEnable = 1'b1;
        frame(fire);
        ScrollEnable = 1'b0;
`ifdef BULLET_SCROLL_COMP_EN
        exp_x = 137;
`else
        exp_x = 138;
`endif
        check_at("scroll pos", exp_x, 212);

        // Reset wins over a tick with a pending request
        clear_play();
        pulse_shoot();
        @(negedge Clk);
        VS    = 1'b1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("reset vs tick fire", int'(fireEvent), 0);
        check("reset vs tick count", int'(activeCount), 0);
        @(negedge Clk);
        Reset = 1'b0;
        VS    = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
